bpsk_tx: RTL and testbench
==========================

// Module: bpsk_tx
// PURPOSE
//   BPSK burst transmitter; the modulating end of the Costas-loop carrier-recovery receiver.
//   Accepts a serial bit stream (valid/ready), sends a carrier-lock preamble of '1' symbols,
//   then the data, on an internal NCO carrier. Output is a signed 8-bit sample stream,
//   one sample per ce, suitable for the receiver's 8-bit din.
// PARAMETERS
//   FREQ_WORD      32'h2000_0000  phase increment per sample (fc = fs*FREQ_WORD/2^32; default fs/8)
//   PHASE_INIT     32'h0000_0000  phase accumulator value after reset
//   SPS            8              samples per symbol, >= 2
//   PREAMBLE_SYMS  16             number of preamble '1' symbols per burst, >= 1
// PORTS
//   clk        in   1  sample clock
//   rst_n      in   1  reset, synchronous, active-low
//   ce         in   1  sample enable; all state advances only when ce=1
//   bit_valid  in   1  bit_data holds a bit to send
//   bit_data   in   1  data bit (1 -> 0 deg carrier, 0 -> 180 deg)
//   bit_ready  out  1  combinational; bit accepted when bit_valid && bit_ready
//   dout       out  8  signed modulated sample, registered
//   dout_valid out  1  registered copy of ce; high for every emitted sample
//   busy       out  1  high in PREAMBLE or DATA state
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge, overrides ce): state=IDLE, phase_acc=PHASE_INIT, sym_cnt=0,
//     pre_cnt=0, cur_sym=1, dout=0, dout_valid=0, busy=0. Reset mid-burst drops the burst.
//   Carrier: phase_acc += FREQ_WORD on every ce (all states; wraps mod 2^32, continuous).
//     s = LUT(phase_acc[31:24]); 64-entry quarter-wave ROM, q[k]=round(127*sin(2*pi*k/256)),
//     quadrant symmetry from idx[7:6]; range -127..127 (never -128).
//   Sample on ce: dout <= (state==IDLE) ? 0 : (cur_sym ? s : -s), using phase_acc BEFORE the
//     increment; one clk latency. dout_valid <= ce. When ce=0, dout holds and dout_valid=0.
//   FSM (transitions only on ce):
//     IDLE:     bit_valid=1 -> PREAMBLE, sym_cnt=0, pre_cnt=0, cur_sym=1 (bit not consumed).
//     PREAMBLE: sym_cnt counts 0..SPS-1 and wraps; on wrap pre_cnt++. At sym_cnt==SPS-1 and
//               pre_cnt==PREAMBLE_SYMS-1: bit_ready=1; handshake -> DATA, cur_sym<=enc(bit);
//               no handshake -> IDLE (empty burst).
//     DATA:     at sym_cnt==SPS-1: bit_ready=1; handshake -> stay DATA, cur_sym<=enc(bit);
//               no handshake -> IDLE (end of burst, next sample is 0).
//   bit_ready = ce && sym_cnt==SPS-1 && (state==DATA || (state==PREAMBLE &&
//     pre_cnt==PREAMBLE_SYMS-1)); low in IDLE and at all other times. Exactly one ready per
//     symbol; bit_valid held across a non-ready cycle is not consumed.
//   Simultaneous: rst_n=0 wins over ce and handshake; bit_valid dropping exactly at the boundary
//     cycle ends the burst (no partial symbols; every sent symbol is exactly SPS samples).
//   enc(b) = b unless DIFF_ENC_EN (below). busy = (state != IDLE), registered with state.
// CONFIGURATION
//   `define BPSK_TX_DIFF_ENC_EN: differential encoding to remove the receiver's 180 deg ambiguity:
//     enc(b) = cur_sym ^ b (1 toggles carrier phase); reference is the preamble symbol (1).
//   Not defined: enc(b) = b, absolute BPSK.
// TESTING
//   1 Reset: rst_n=0 for 3 clk with ce=1 -> dout=0, dout_valid=0, busy=0, bit_ready=0.
//   2 Idle: ce=1, bit_valid=0 for 20 clk -> dout=0 every sample, dout_valid=1, phase still
//     advances (first burst sample after N idle samples uses index (N*32) mod 256).
//   3 Burst, SPS=8, PREAMBLE_SYMS=2, defaults, ce=1, bits 1,0 -> 16 preamble samples cycling
//     0,90,127,90,0,-90,-127,-90 (from entry phase), 8 identical for bit 1, 8 negated for bit 0,
//     then 0s; busy high 32 samples; bit_ready high exactly at samples 16 and 24 (and 32).
//   4 Rate: ce=1 every 2nd clk -> bit_ready period 16 clk, dout_valid 50% duty, dout unchanged
//     on ce=0 cycles; sample sequence identical to test 3.
//   5 Underrun/reset: bit_valid low at a DATA boundary -> IDLE, next dout=0, busy=0; rst_n=0 in
//     middle of a symbol -> next clk dout=0, phase=PHASE_INIT.
//   6 BPSK_TX_DIFF_ENC_EN: bits 1,0,0,1 -> symbols 0,0,0,1 (carrier -,-,-,+ vs preamble);
//     without macro -> +,-,-,+.

Source files
------------

// File: rtl/bpsk_tx_if.sv
// bpsk_tx_if
//   Sample enable, serial bit handshake and modulated sample stream of bpsk_tx.
//   master: the side that feeds bits and consumes samples.
//   slave : the transmitter itself.
interface bpsk_tx_if;
   logic              ce;          // sample enable
   logic              bit_valid;   // bit_data holds a bit to send
   logic              bit_data;    // 1 -> 0 deg carrier, 0 -> 180 deg
   logic              bit_ready;   // bit accepted when bit_valid && bit_ready
   logic signed [7:0] dout;        // modulated sample
   logic              dout_valid;  // high for every emitted sample
   logic              busy;        // burst in progress

   modport master (
      output ce, bit_valid, bit_data,
      input  bit_ready, dout, dout_valid, busy
   );

   modport slave (
      input  ce, bit_valid, bit_data,
      output bit_ready, dout, dout_valid, busy
   );
endinterface : bpsk_tx_if

// File: rtl/bpsk_tx.sv
// bpsk_tx
//   BPSK burst transmitter. On the first valid bit it sends PREAMBLE_SYMS '1'
//   symbols for carrier lock, then one symbol of SPS samples per accepted bit,
//   and returns to idle (zero output) when no bit is offered at a symbol
//   boundary. The carrier is a free-running 32-bit NCO read through a
//   quarter-wave sine ROM; every state advance is qualified by ce.
//
//   Optional build macro:
//     BPSK_TX_DIFF_ENC_EN  differential encoding, a '1' bit toggles the carrier
//                          phase relative to the previous symbol (the preamble
//                          symbol is the reference). Undefined: absolute BPSK.
module bpsk_tx #(
   parameter logic [31:0] FREQ_WORD     = 32'h2000_0000,  // phase step per sample
   parameter logic [31:0] PHASE_INIT    = 32'h0000_0000,  // accumulator after reset
   parameter int unsigned SPS           = 8,              // samples per symbol, >= 2
   parameter int unsigned PREAMBLE_SYMS = 16              // preamble symbols, >= 1
) (
   input  logic     clk,
   input  logic     rst_n,
   bpsk_tx_if.slave bus
);

   localparam int unsigned      SYM_W    = $clog2(SPS);
   localparam int unsigned      PRE_W    = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SPS - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_SYMS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA
   } state_e;

   // Registered state and its next-state values.
   state_e            state_q,      state_d;
   logic [31:0]       phase_acc_q,  phase_acc_d;
   logic [SYM_W-1:0]  sym_cnt_q,    sym_cnt_d;
   logic [PRE_W-1:0]  pre_cnt_q,    pre_cnt_d;
   logic              cur_sym_q,    cur_sym_d;
   logic signed [7:0] dout_q,       dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              busy_q,       busy_d;

   // Carrier lookup.
   logic [7:0]        lut_idx;
   logic [5:0]        rom_addr;
   logic [6:0]        magnitude;
   logic signed [7:0] carrier;

   // Handshake.
   logic sym_last;
   logic pre_last;
   logic bit_ready;
   logic accept;
   logic enc_bit;

   // NOTE: the sine table is a constant ROM built from logic, so it has no
   // storage to reset; only the registers below take rst_n.
   // q[k] = round(127*sin(2*pi*k/256)) for the first quarter of the cycle.
   function automatic logic [6:0] quarter_sine(input logic [5:0] addr);
      logic [6:0] q;
      unique case (addr)
         6'd0:  q = 7'd0;
         6'd1:  q = 7'd3;
         6'd2:  q = 7'd6;
         6'd3:  q = 7'd9;
         6'd4:  q = 7'd12;
         6'd5:  q = 7'd16;
         6'd6:  q = 7'd19;
         6'd7:  q = 7'd22;
         6'd8:  q = 7'd25;
         6'd9:  q = 7'd28;
         6'd10: q = 7'd31;
         6'd11: q = 7'd34;
         6'd12: q = 7'd37;
         6'd13: q = 7'd40;
         6'd14: q = 7'd43;
         6'd15: q = 7'd46;
         6'd16: q = 7'd49;
         6'd17: q = 7'd51;
         6'd18: q = 7'd54;
         6'd19: q = 7'd57;
         6'd20: q = 7'd60;
         6'd21: q = 7'd63;
         6'd22: q = 7'd65;
         6'd23: q = 7'd68;
         6'd24: q = 7'd71;
         6'd25: q = 7'd73;
         6'd26: q = 7'd76;
         6'd27: q = 7'd78;
         6'd28: q = 7'd81;
         6'd29: q = 7'd83;
         6'd30: q = 7'd85;
         6'd31: q = 7'd88;
         6'd32: q = 7'd90;
         6'd33: q = 7'd92;
         6'd34: q = 7'd94;
         6'd35: q = 7'd96;
         6'd36: q = 7'd98;
         6'd37: q = 7'd100;
         6'd38: q = 7'd102;
         6'd39: q = 7'd104;
         6'd40: q = 7'd106;
         6'd41: q = 7'd107;
         6'd42: q = 7'd109;
         6'd43: q = 7'd111;
         6'd44: q = 7'd112;
         6'd45: q = 7'd113;
         6'd46: q = 7'd115;
         6'd47: q = 7'd116;
         6'd48: q = 7'd117;
         6'd49: q = 7'd118;
         6'd50: q = 7'd120;
         6'd51: q = 7'd121;
         6'd52: q = 7'd122;
         6'd53: q = 7'd122;
         6'd54: q = 7'd123;
         6'd55: q = 7'd124;
         6'd56: q = 7'd125;
         6'd57: q = 7'd125;
         6'd58: q = 7'd126;
         6'd59: q = 7'd126;
         6'd60: q = 7'd126;
         6'd61: q = 7'd127;
         6'd62: q = 7'd127;
         6'd63: q = 7'd127;
         default: q = 7'd0;
      endcase
      return q;
   endfunction

   // Unfold the quarter-wave ROM to a full cycle: bit 6 mirrors the address
   // (the peak at 90 deg lies one past the table), bit 7 negates the result.
   always_comb begin
      lut_idx   = phase_acc_q[31:24];
      rom_addr  = lut_idx[6] ? (6'd0 - lut_idx[5:0]) : lut_idx[5:0];
      magnitude = (lut_idx[6] && (lut_idx[5:0] == 6'd0)) ? 7'd127 : quarter_sine(rom_addr);
      carrier   = lut_idx[7] ? -$signed({1'b0, magnitude}) : $signed({1'b0, magnitude});
   end

   // A bit is taken only on the last sample of the final preamble symbol or
   // of a data symbol, so every symbol on air is exactly SPS samples long.
   assign sym_last  = (sym_cnt_q == SYM_LAST);
   assign pre_last  = (pre_cnt_q == PRE_LAST);
   assign bit_ready = bus.ce && sym_last &&
                      ((state_q == ST_DATA) || ((state_q == ST_PREAMBLE) && pre_last));
   assign accept    = bit_ready && bus.bit_valid;

`ifdef BPSK_TX_DIFF_ENC_EN
   assign enc_bit = cur_sym_q ^ bus.bit_data;
`else
   assign enc_bit = bus.bit_data;
`endif

   // Next-state logic: NCO step, output sample and burst sequencing per ce.
   always_comb begin
      // NOTE: every variable gets its hold value first, so branches that do
      // not assign it cannot infer a latch.
      state_d      = state_q;
      phase_acc_d  = phase_acc_q;
      sym_cnt_d    = sym_cnt_q;
      pre_cnt_d    = pre_cnt_q;
      cur_sym_d    = cur_sym_q;
      dout_d       = dout_q;
      dout_valid_d = bus.ce;
      busy_d       = busy_q;

      if (bus.ce) begin
         phase_acc_d = phase_acc_q + FREQ_WORD;
         // Sample uses the phase before this step and the current symbol.
         if (state_q == ST_IDLE) begin
            dout_d = '0;
         end else begin
            dout_d = cur_sym_q ? carrier : -carrier;
         end

         unique case (state_q)
            ST_IDLE: begin
               // The waiting bit only opens the burst; it is sent after the preamble.
               if (bus.bit_valid) begin
                  state_d   = ST_PREAMBLE;
                  sym_cnt_d = '0;
                  pre_cnt_d = '0;
                  cur_sym_d = 1'b1;
               end
            end
            ST_PREAMBLE: begin
               if (!sym_last) begin
                  sym_cnt_d = sym_cnt_q + 1'b1;
               end else if (!pre_last) begin
                  sym_cnt_d = '0;
                  pre_cnt_d = pre_cnt_q + 1'b1;
               end else begin
                  sym_cnt_d = '0;
                  pre_cnt_d = '0;
                  if (accept) begin
                     state_d   = ST_DATA;
                     cur_sym_d = enc_bit;
                  end else begin
                     state_d = ST_IDLE;  // empty burst
                  end
               end
            end
            ST_DATA: begin
               if (!sym_last) begin
                  sym_cnt_d = sym_cnt_q + 1'b1;
               end else begin
                  sym_cnt_d = '0;
                  if (accept) begin
                     cur_sym_d = enc_bit;
                  end else begin
                     state_d = ST_IDLE;  // underrun ends the burst
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase

         busy_d = (state_d != ST_IDLE);
      end
   end

   // State registers with synchronous reset; reset drops any burst in flight.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register sample its _d
      // value from the same clock edge, independent of statement order.
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         phase_acc_q  <= PHASE_INIT;
         sym_cnt_q    <= '0;
         pre_cnt_q    <= '0;
         cur_sym_q    <= 1'b1;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_acc_q  <= phase_acc_d;
         sym_cnt_q    <= sym_cnt_d;
         pre_cnt_q    <= pre_cnt_d;
         cur_sym_q    <= cur_sym_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.bit_ready  = bit_ready;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.busy       = busy_q;

endmodule : bpsk_tx

// File: tb/tb_bpsk_tx.sv
// tb_bpsk_tx
//   Directed and randomized bursts for bpsk_tx (SPS=8, PREAMBLE_SYMS=2).
//   Expected samples come from a burst-level model: sample n of a burst is
//   sign(symbol n/SPS) * round(127*sin(2*pi*phase[31:24]/256)), with the
//   phase advanced by FREQ_WORD on every ce.
module tb_bpsk_tx;

   localparam logic [31:0] FW    = 32'h2000_0000;
   localparam logic [31:0] PINIT = 32'h0000_0000;
   localparam int          SPS   = 8;
   localparam int          PRE   = 2;
   localparam real         PI    = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst_n;

   bpsk_tx_if bus ();

   bpsk_tx #(
      .FREQ_WORD    (FW),
      .PHASE_INIT   (PINIT),
      .SPS          (SPS),
      .PREAMBLE_SYMS(PRE)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   int                checks = 0;
   int                errors = 0;
   logic [31:0]       model_phase;
   logic signed [31:0] exp_dout;
   logic              exp_busy;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sine_ref(input logic [31:0] ph);
      real r;
      r = 127.0 * $sin(2.0 * PI * real'(ph[31:24]) / 256.0);
      return (r >= 0.0) ? int'($floor(r + 0.5)) : -int'($floor(-r + 0.5));
   endfunction

   // One clock: drive at the falling edge, sample bit_ready before the rising
   // edge, return 1 time unit after it so registered outputs are stable.
   task automatic drive_cycle(input logic ce_v, input logic valid_v, input logic data_v,
                              input logic rst_v, output logic ready_seen);
      @(negedge clk);
      bus.ce        = ce_v;
      bus.bit_valid = valid_v;
      bus.bit_data  = data_v;
      rst_n         = rst_v;
      #2;
      ready_seen = bus.bit_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic run_idle(input int n);
      logic rdy;
      for (int i = 0; i < n; i++) begin
         drive_cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, rdy);
         model_phase = model_phase + FW;
         exp_dout    = 0;
         exp_busy    = 1'b0;
         check("idle_ready", 32'(rdy), 0);
         check("idle_dout", bus.dout, exp_dout);
         check("idle_dout_valid", 32'(bus.dout_valid), 1);
         check("idle_busy", 32'(bus.busy), 0);
      end
   endtask

   // One burst of nbits data bits (bits[0] first), ce every ce_div clocks.
   // abort_k >= 0 pulses reset on that ce sample of the burst.
   task automatic run_burst(input string name, input int nbits, input logic [7:0] bits,
                            input int ce_div, input int abort_k);
      int   sign [0:15];
      int   prev, nsym, len, k, cyc, consumed;
      logic ce_v, valid_v, data_v, rst_v, rdy, exp_rdy;

      nsym = PRE + nbits;
      len  = nsym * SPS;
      prev = 1;
      for (int j = 0; j < nsym; j++) begin
         if (j < PRE) begin
            sign[j] = 1;
         end else begin
`ifdef BPSK_TX_DIFF_ENC_EN
            prev = prev ^ int'(bits[j-PRE]);
`else
            prev = int'(bits[j-PRE]);
`endif
            sign[j] = (prev != 0) ? 1 : -1;
         end
      end

      k        = 0;
      cyc      = 0;
      consumed = 0;
      while (k <= len + 3) begin
         ce_v    = ((cyc % ce_div) == 0);
         valid_v = (k == 0) || (consumed < nbits);
         data_v  = (consumed < nbits) ? bits[consumed] : 1'($urandom_range(0, 1));
         rst_v   = !(ce_v && (k == abort_k));
         drive_cycle(ce_v, valid_v, data_v, rst_v, rdy);

         if (!rst_v) begin
            model_phase = PINIT;
            exp_dout    = 0;
            exp_busy    = 1'b0;
            check({name, "_rst_dout"}, bus.dout, 0);
            check({name, "_rst_dout_valid"}, 32'(bus.dout_valid), 0);
            check({name, "_rst_busy"}, 32'(bus.busy), 0);
            return;
         end

         exp_rdy = ce_v && (k >= PRE * SPS) && (k <= len) && (((k - PRE * SPS) % SPS) == 0);
         check({name, "_ready"}, 32'(rdy), 32'(exp_rdy));
         if (rdy && valid_v) consumed++;

         if (ce_v) begin
            exp_dout    = (k >= 1 && k <= len) ? sign[(k - 1) / SPS] * sine_ref(model_phase) : 0;
            model_phase = model_phase + FW;
            exp_busy    = (k < len);
            k++;
         end
         check({name, "_dout"}, bus.dout, exp_dout);
         check({name, "_dout_valid"}, 32'(bus.dout_valid), 32'(ce_v));
         check({name, "_busy"}, 32'(bus.busy), 32'(exp_busy));
         cyc++;
      end
   endtask

   initial begin
      int nb, cd, ab;
      logic [7:0] rb;

      bus.ce        = 1'b1;
      bus.bit_valid = 1'b1;
      bus.bit_data  = 1'b0;
      rst_n         = 1'b0;
      model_phase   = PINIT;
      exp_dout      = 0;
      exp_busy      = 1'b0;

      // Reset held 3 clocks with ce and bit_valid high.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_dout", bus.dout, 0);
         check("reset_dout_valid", 32'(bus.dout_valid), 0);
         check("reset_busy", 32'(bus.busy), 0);
         check("reset_ready", 32'(bus.bit_ready), 0);
      end

      run_idle(20);
      run_burst("burst_1_0", 2, 8'b0000_0001, 1, -1);
      run_idle(3);
      run_burst("burst_1_0_half_rate", 2, 8'b0000_0001, 2, -1);
      run_idle(2);
      run_burst("burst_1001", 4, 8'b0000_1001, 1, -1);
      run_burst("empty_burst", 0, 8'h00, 1, -1);
      run_burst("mid_symbol_reset", 3, 8'($urandom), 1, 20);
      run_idle(4);
      run_burst("after_reset", 1, 8'b0000_0001, 1, -1);

      for (int r = 0; r < 6; r++) begin
         nb = $urandom_range(0, 5);
         rb = 8'($urandom);
         cd = $urandom_range(1, 3);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (PRE + nb) * SPS) : -1;
         run_burst("random_burst", nb, rb, cd, ab);
         run_idle($urandom_range(1, 4));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_bpsk_tx
